// File: rtl/adc_trim_mean_filter_if.sv
// Sample/result bus for adc_trim_mean_filter: tagged sample input, mode select,
// result strobe and the sticky drop flag.
interface adc_trim_mean_filter_if #(
    parameter int DW  = 14,
    parameter int CHW = 1
);
    logic [1:0]     mode;
    logic           in_valid;
    logic [CHW-1:0] in_ch;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  out_data;
    logic           drop_err;

    modport master (
        output mode, in_valid, in_ch, in_data,
        input  out_valid, out_ch, out_data, drop_err
    );

    modport slave (
        input  mode, in_valid, in_ch, in_data,
        output out_valid, out_ch, out_data, drop_err
    );
endinterface

// File: rtl/adc_trim_mean_filter.sv
// Per-channel windowed trimmed/plain mean filter for ADC samples, with bypass.
// One result per channel per window, registered one cycle after the last sample.
module adc_trim_mean_filter #(
    parameter int DW       = 14,
    parameter int CH       = 2,
    parameter int CHW      = 1,
    parameter int LOG2_AVG = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    adc_trim_mean_filter_if.slave     bus
);
    localparam int unsigned AW    = DW + LOG2_AVG + 2;
    localparam int unsigned CW    = LOG2_AVG + 2;
    localparam int unsigned NSLOT = 2 ** CHW;

    localparam logic [CW-1:0]  LAST_TRIM  = CW'(2 ** LOG2_AVG + 1);
    localparam logic [CW-1:0]  LAST_PLAIN = CW'(2 ** LOG2_AVG - 1);
    localparam logic [AW-1:0]  HALF       = AW'(2 ** (LOG2_AVG - 1));
    localparam logic [CHW:0]   CH_LIM     = (CHW + 1)'(CH);
    localparam logic [1:0]     MODE_PLAIN = 2'd1;
    localparam logic [1:0]     MODE_BYP   = 2'd2;

    logic [CW-1:0]  r_cnt [NSLOT];
    logic [AW-1:0]  r_acc [NSLOT];
    logic [DW-1:0]  r_max [NSLOT];
    logic [DW-1:0]  r_min [NSLOT];
    logic [1:0]     r_mode_q;
    logic           r_out_valid;
    logic [CHW-1:0] r_out_ch;
    logic [DW-1:0]  r_out_data;
    logic           r_drop_err;

    logic           w_ch_ok;
    logic           w_mode_chg;
    logic           w_accept;
    logic           w_plain;
    logic           w_bypass;
    logic           w_last;
    logic [AW-1:0]  w_sum;
    logic [DW-1:0]  w_max;
    logic [DW-1:0]  w_min;
    logic [AW-1:0]  w_rounded;
    logic [DW-1:0]  w_res;

    // Slots at or above CH exist only so in_ch can index directly; they are never written.
    always_comb begin
        w_ch_ok    = {1'b0, bus.in_ch} < CH_LIM;
        w_mode_chg = bus.mode != r_mode_q;
        w_accept   = bus.in_valid && w_ch_ok && !w_mode_chg;
        w_plain    = r_mode_q == MODE_PLAIN;
        w_bypass   = r_mode_q == MODE_BYP;
        w_sum      = r_acc[bus.in_ch] + AW'(bus.in_data);
        w_max      = (bus.in_data >= r_max[bus.in_ch]) ? bus.in_data : r_max[bus.in_ch];
        w_min      = (bus.in_data <= r_min[bus.in_ch]) ? bus.in_data : r_min[bus.in_ch];
        w_last     = r_cnt[bus.in_ch] == (w_plain ? LAST_PLAIN : LAST_TRIM);
        if (w_plain)
            w_rounded = w_sum + HALF;
        else
            w_rounded = w_sum - AW'(w_max) - AW'(w_min) + HALF;
        w_res = DW'(w_rounded >> LOG2_AVG);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                r_cnt[i] <= '0;
                r_acc[i] <= '0;
                r_max[i] <= '0;
                r_min[i] <= '1;
            end
            r_mode_q    <= bus.mode;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.in_valid && !w_ch_ok)
                r_drop_err <= 1'b1;

            if (w_mode_chg) begin
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    r_cnt[i] <= '0;
                    r_acc[i] <= '0;
                    r_max[i] <= '0;
                    r_min[i] <= '1;
                end
                r_mode_q <= bus.mode;
            end else if (w_accept) begin
                if (w_bypass) begin
                    r_out_valid <= 1'b1;
                    r_out_ch    <= bus.in_ch;
                    r_out_data  <= bus.in_data;
                end else if (w_last) begin
                    r_out_valid         <= 1'b1;
                    r_out_ch            <= bus.in_ch;
                    r_out_data          <= w_res;
                    r_cnt[bus.in_ch]    <= '0;
                    r_acc[bus.in_ch]    <= '0;
                    r_max[bus.in_ch]    <= '0;
                    r_min[bus.in_ch]    <= '1;
                end else begin
                    r_cnt[bus.in_ch]    <= r_cnt[bus.in_ch] + 1'b1;
                    r_acc[bus.in_ch]    <= w_sum;
                    r_max[bus.in_ch]    <= w_max;
                    r_min[bus.in_ch]    <= w_min;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
    assign bus.drop_err  = r_drop_err;
endmodule
